// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7 scan driver: segment patterns, blank code,
// slot phase type and the digit-index width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high {g,f,e,d,c,b,a} patterns, entry 15 (F) first so SEG_PAT[n] is hex n.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
    7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
    7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
    7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  typedef enum logic {SLOT_DEAD, SLOT_LIT} slot_t;

  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_if.sv
// Value-side and pin-side signals of the seg7 scan driver.
interface seg7_if
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (output load, value, dp_in, blank_in,
                  input  seg, dp, an, frame_tick);
  modport slave  (input  load, value, dp_in, blank_in,
                  output seg, dp, an, frame_tick);
endinterface

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = ~SEG_PAT[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver with dead time and frame-coherent
// updates. Define SEG7_LZ_BLANK_EN for leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
)(
  input  logic clk,
  input  logic rst,
  seg7_if.slave bus
);
  localparam int IW = idx_width(DIGITS);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic                 slot_wrap, frame_wrap;
  logic [4*DIGITS-1:0]  value_sh, value_disp;
  logic [DIGITS-1:0]    dp_sh, dp_disp, blank_sh, blank_disp, blank_eff;
  logic [3:0]           nib;
  logic [6:0]           seg_dec;
  slot_t                slot;
  logic [DIGITS-1:0]    an_nxt, an_q;
  logic [6:0]           seg_nxt, seg_q;
  logic                 dp_nxt, dp_q, tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

  always_comb begin
    slot_wrap  = (cnt == CNT_LAST);
    frame_wrap = slot_wrap && (idx == IDX_LAST);
    cnt_nxt    = slot_wrap ? '0 : cnt + 1'b1;
    idx_nxt    = idx;
    if (slot_wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  // Display only changes at frame wrap; a load on that same edge bypasses the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_sh   <= '0;
      dp_sh      <= '0;
      blank_sh   <= '0;
      value_disp <= '0;
      dp_disp    <= '0;
      blank_disp <= '0;
    end else begin
      if (bus.load) begin
        value_sh <= bus.value;
        dp_sh    <= bus.dp_in;
        blank_sh <= bus.blank_in;
      end
      if (frame_wrap) begin
        value_disp <= bus.load ? bus.value    : value_sh;
        dp_disp    <= bus.load ? bus.dp_in    : dp_sh;
        blank_disp <= bus.load ? bus.blank_in : blank_sh;
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;
  always_comb begin
    logic lead;
    lead = 1'b1;
    lz   = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (value_disp[4*i +: 4] == 4'h0) && !dp_disp[i]) lz[i] = 1'b1;
      else lead = 1'b0;
    end
  end
  assign blank_eff = blank_disp | lz;
`else
  assign blank_eff = blank_disp;
`endif

  assign nib = value_disp[4*idx +: 4];

  hex_seg_decode u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  always_comb begin
    slot    = (cnt == '0) ? SLOT_DEAD : SLOT_LIT;
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (slot == SLOT_LIT && !blank_eff[idx]) begin
      an_nxt  = ~(DIGITS'(1) << idx);
      seg_nxt = seg_dec;
      dp_nxt  = ~dp_disp[idx];
    end
  end

  // Output registers: pins show the slot state of the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q   <= '1;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_nxt;
      seg_q  <= seg_nxt;
      dp_q   <= dp_nxt;
      tick_q <= frame_wrap;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, PRESCALE=4): vector table plus scan
// scoreboard, with hand-written reset, mid-frame and wrap-cycle load sequences.
module tb_seg7_scan_driver;
  localparam int D = 4, P = 4, FRAME = D * P;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp_in;
    logic [3:0]      blank_in;
    logic [3:0][6:0] seg;
    logic [3:0]      lit;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    logic       full;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_if #(.DIGITS(D)) bus ();

  seg7_scan_driver #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t tbl [6];
  vec_t cur, pend, ld;
  exp_t sbq [$];
  int   k;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [15:0] v, input logic [3:0] d,
                              input logic [3:0] b, input logic [27:0] s,
                              input logic [3:0] lit);
    vec_t r;
    r.value = v; r.dp_in = d; r.blank_in = b; r.seg = s; r.lit = lit;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL sb_empty: no expected entry at k=%0d", k);
      return;
    end
    e = sbq.pop_front();
    chk($sformatf("an@k%0d", k), bus.an, e.an);
    chk($sformatf("tick@k%0d", k), bus.frame_tick, e.tick);
    if (e.full) begin
      chk($sformatf("seg@k%0d", k), bus.seg, e.seg);
      chk($sformatf("dp@k%0d", k), bus.dp, e.dp);
    end
  endtask

  // One clock: push the expected pin state for this edge, then compare after it.
  task automatic step();
    exp_t e;
    int   c, i;
    c      = k % P;
    i      = (k / P) % D;
    e.tick = ((k % FRAME) == FRAME - 1);
    e.an   = 4'hF;
    e.seg  = 7'h7F;
    e.dp   = 1'b1;
    e.full = 1'b1;
    if (c != 0) begin
      if (cur.lit[i]) begin
        e.an  = ~(4'b0001 << i);
        e.seg = cur.seg[i];
        e.dp  = ~cur.dp_in[i];
      end else begin
        e.full = 1'b0;
      end
    end
    sbq.push_back(e);
    if (bus.load) pend = ld;
    if ((k % FRAME) == FRAME - 1) cur = pend;
    @(posedge clk);
    #1;
    compare();
    k++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic goto_pos(input int pos);
    while ((k % FRAME) != pos) step();
  endtask

  task automatic load_vec(input vec_t v);
    ld           = v;
    bus.value    = v.value;
    bus.dp_in    = v.dp_in;
    bus.blank_in = v.blank_in;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic restart();
    k    = 0;
    cur  = tbl[0];
    pend = tbl[0];
    sbq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = mk(16'h0000, 4'b0000, 4'b0000,
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, LZ ? 4'b0001 : 4'b1111);
    tbl[1] = mk(16'h12AF, 4'b0010, 4'b0000,
                {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111);
    tbl[2] = mk(16'h8888, 4'b0000, 4'b0000,
                {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 4'b1111);
    tbl[3] = mk(16'hFFFF, 4'b0000, 4'b0100,
                {7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110}, 4'b1011);
    tbl[4] = mk(16'h0050, 4'b0000, 4'b0000,
                {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}, LZ ? 4'b0011 : 4'b1111);
    tbl[5] = mk(16'h0050, 4'b0100, 4'b0000,
                {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}, LZ ? 4'b0111 : 4'b1111);

    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_an", bus.an, 4'hF);
    chk("reset_seg", bus.seg, 7'h7F);
    chk("reset_dp", bus.dp, 1'b1);
    chk("reset_tick", bus.frame_tick, 1'b0);
    rst = 1'b0;
    restart();

    // Scan order and frame_tick cadence with an all-zero value.
    load_vec(tbl[0]);
    run(2 * FRAME);

    // Table vectors, each loaded at a different point in the frame.
    for (int v = 1; v < 6; v++) begin
      run(3 * v);
      load_vec(tbl[v]);
      run(2 * FRAME);
    end

    // Asynchronous reset while digit 2 is lit at cnt=3.
    load_vec(tbl[1]);
    run(2 * FRAME);
    goto_pos(11);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_an", bus.an, 4'hF);
    chk("midrst_seg", bus.seg, 7'h7F);
    chk("midrst_dp", bus.dp, 1'b1);
    chk("midrst_tick", bus.frame_tick, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    restart();
    run(FRAME);

    // Load during the digit 2 slot: rest of the frame keeps the old contents.
    goto_pos(9);
    load_vec(tbl[2]);
    run(2 * FRAME);

    // Load on the wrap cycle: shown in the very next frame, digit 2 blanked.
    goto_pos(FRAME - 1);
    load_vec(tbl[3]);
    run(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a common-anode 7-segment display bank. It holds a DIGITS-wide hex value and scans one digit per slot. It generalises the single-digit hex decoder to N digits, with per-digit decimal point and blanking, anti-ghosting dead time, and frame-coherent updates. It sits between the user/debug logic that produces values and the board pins for segments and anodes.

## Interface
- DIGITS, 4: number of digits, 1..8
- PRESCALE, 50000: clock cycles per digit slot, ≥2
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  capture value/dp_in/blank_in into shadow this cycle
- value  in  4*DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- blank_in  in  DIGITS  force digit dark, 1 = blank
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  DIGITS  digit enables, active-low, at most one low
- frame_tick  out  1  one-cycle pulse at each frame wrap

## Operation
- Shadow registers (value/dp/blank) written on any clk edge with load=1. They hold otherwise.
- Display registers are copied from shadow at frame wrap only. Frame wrap is cnt==PRESCALE-1 && idx==DIGITS-1.
- load coincident with wrap: the new inputs bypass into the display registers and are shown in the new frame.
- Prescaler cnt counts 0..PRESCALE-1 and wraps. On wrap, idx advances 0,1,…,DIGITS-1,0. DIGITS=1 keeps idx=0.
- Hex decode, active-high before inversion:
  - 0:0111111, 1:0000110, 2:1011011, 3:1001111
  - 4:1100110, 5:1101101, 6:1111101, 7:0000111
  - 8:1111111, 9:1101111, A:1110111, b:1111100
  - C:0111001, d:1011110, E:1111001, F:1110001
  - seg outputs the bitwise inverse.
- Per slot, the first output cycle is dead time: an all 1, seg 7'h7F, dp 1.
- The remaining PRESCALE-1 cycles drive an[idx]=0, seg=decode(nibble idx), dp=~dp_disp[idx].
- A blanked digit keeps all an high for the whole slot. Slot timing is unchanged, so brightness stays uniform.
- frame_tick=1 on the output cycle following the frame wrap.

## Timing
- All outputs are registered. Outputs reflect the (cnt, idx) of the previous cycle.
- Reset values: cnt=0, idx=0, shadow=0, display=0, an all 1, seg=7'h7F, dp=1, frame_tick=0.
- Asserting rst mid-slot forces the reset values immediately (asynchronous). Scanning restarts at digit 0 slot 0 after deassertion.
- The first output cycle after reset release is dead time.
- Frame period: DIGITS*PRESCALE cycles. frame_tick period is identical.
- Latency from load to display: the next frame wrap, worst case DIGITS*PRESCALE cycles.
- No digit changes content mid-frame.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero suppression. Scanning from digit DIGITS-1 downward, a digit is blanked while its nibble==0 and its dp is 0, up to the first non-blank digit. Digit 0 is never suppressed. blank_in still ORs in.
- Not defined: only blank_in blanks digits. Zero nibbles display "0".

## Structure
- Shared package seg7_pkg holds:
  - the 16-entry active-high segment pattern constant
  - SEG_OFF = 7'h7F
  - a function returning the idx width, max($clog2(DIGITS),1)
- Sub-module hex_seg_decode: 4-bit nibble in, 7-bit active-low pattern out, purely combinational, from seg7_pkg.
- Counter, scan FSM, shadow/display registers and output registers live in seg7_scan_driver.

## Test plan
All with DIGITS=4, PRESCALE=4.
1. Reset mid-scan (idx=2, cnt=3). Required response, same cycle: an=4'b1111, seg=7'h7F, dp=1, frame_tick=0. After release, first lit slot is digit 0.
2. Scan order: load 16'h0000, blank 0. Required an sequence 1111,1110,1110,1110,1111,1101×3,1111,1011×3,1111,0111×3. frame_tick pulses once every 16 cycles.
3. Decode: load 16'h12AF, dp_in 4'b0010, then wait one wrap. Required outputs:
   - digit 0: seg=7'b0001110
   - digit 1: seg=7'b0001000, dp=0
   - digit 2: seg=7'b0100100
   - digit 3: seg=7'b1111001
4. Mid-frame load: display 16'h0000, load 16'h8888 during the digit 2 slot. Digits 2 and 3 keep seg=7'b1000000. The next frame shows seg=7'b0000000 on all digits.
5. Load on the wrap cycle with 16'hFFFF. The new frame digit 0 shows seg=7'b0001110 with no frame of delay. blank_in=4'b0100 keeps an[2]=1 during the whole slot 2.
6. SEG7_LZ_BLANK_EN:
   - 16'h0050: digits 3 and 2 dark, digit 1 shows 5 (7'b0010010), digit 0 shows 0 (7'b1000000).
   - 16'h0000: only digit 0 lit.
   - 16'h0050 with dp_in 4'b0100: digit 2 lit.
